jk_pattern_driver: RTL and testbench

Serial pattern driver for a negedge-triggered JK flip-flop, acting as the input side of the JK flop interface. It accepts a WIDTH-bit target pattern over a valid/ready handshake and replays it LSB-first as J/K excitation, one bit per CLK cycle, so that the attached flop's Q follows the pattern. It optionally checks the flop's Q feedback against an internal model and counts mismatches. The block sits between a stimulus source (bench or control FSM) and one JK flop instance.

---
 rtl/jk_pkg.sv | 29 ++
 rtl/jk_excite.sv | 14 +
 rtl/jk_pattern_driver.sv | 149 ++++++++++++++
 tb/tb_jk_pattern_driver.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared types and constants for the JK pattern driver: FSM states,
// {J,K} excitation encodings and the supported pattern-length range.
package jk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    // Encodings are {J, K}; the toggle pair 2'b11 is deliberately absent.
    localparam logic [1:0] JK_HOLD  = 2'b00;
    localparam logic [1:0] JK_SET   = 2'b10;
    localparam logic [1:0] JK_RESET = 2'b01;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic logic [1:0] jk_encode(input logic q_cur, input logic q_next);
        if (q_cur == q_next) begin
            return JK_HOLD;
        end else if (q_next) begin
            return JK_SET;
        end else begin
            return JK_RESET;
        end
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational JK excitation: picks the {J,K} pair that moves a JK flop
// from q_cur to q_next without ever using the toggle pair.
import jk_pkg::*;

module jk_excite (
    input  logic q_cur,
    input  logic q_next,
    output logic j,
    output logic k
);

    assign {j, k} = jk_encode(q_cur, q_next);

endmodule

// File: rtl/jk_pattern_driver.sv
// Serial JK pattern driver: replays a WIDTH-bit Q pattern LSB-first as J/K.
// Define JK_FB_CHECK_EN to compare Q_FB against the internal Q model.
import jk_pkg::*;

module jk_pattern_driver #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    output logic             J,
    output logic             K,
    input  logic             Q_FB,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_CNT
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               q_m_q, q_m_d;
    logic               j_q, j_d;
    logic               k_q, k_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               next_bit;
    logic               ex_j, ex_k;
    logic               mismatch;

    // In IDLE the first bit comes straight from DATA_IN so bit 0 is driven at the handshake edge.
    assign next_bit = (state_q == ST_IDLE) ? DATA_IN[0] : data_q[0];

    jk_excite u_excite (
        .q_cur  (q_m_q),
        .q_next (next_bit),
        .j      (ex_j),
        .k      (ex_k)
    );

`ifdef JK_FB_CHECK_EN
    assign mismatch = (Q_FB != q_m_q);
`else
    logic unused_q_fb;
    assign unused_q_fb = Q_FB;
    assign mismatch    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        q_m_d   = q_m_q;
        j_d     = 1'b0;
        k_d     = 1'b0;
        ready_d = ready_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;

        // Every edge spent in SHIFT or CHECK checks the bit applied one cycle earlier.
        if ((state_q != ST_IDLE) && mismatch) begin
            err_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (ready_q && LOAD_VALID) begin
                    state_d = ST_SHIFT;
                    data_d  = DATA_IN >> 1;
                    idx_d   = IDX_W'(1);
                    q_m_d   = DATA_IN[0];
                    j_d     = ex_j;
                    k_d     = ex_k;
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_SHIFT: begin
                data_d = data_q >> 1;
                idx_d  = idx_q + 1'b1;
                q_m_d  = data_q[0];
                j_d    = ex_j;
                k_d    = ex_k;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                done_d  = 1'b1;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            q_m_q   <= 1'b0;
            j_q     <= 1'b0;
            k_q     <= 1'b1;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            q_m_q   <= q_m_d;
            j_q     <= j_d;
            k_q     <= k_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign LOAD_READY = ready_q;
    assign J          = j_q;
    assign K          = k_q;
    assign BUSY       = (state_q != ST_IDLE);
    assign DONE       = done_q;
    assign ERR        = err_q;
    assign ERR_CNT    = cnt_q;

endmodule

// File: tb/tb_jk_pattern_driver.sv
// Directed bench for jk_pattern_driver with a negedge JK flop model on Q_FB.
// Feedback-check expectations follow the JK_FB_CHECK_EN build macro.
module tb_jk_pattern_driver;

`ifdef JK_FB_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       load_valid = 1'b0;
    logic       load_ready, j, k, busy, done, err;
    logic [7:0] err_cnt;
    logic       flop_q = 1'b0;
    logic       q_force = 1'b0;
    logic       q_fb;

    logic       ex_q, ex_n, ex_j, ex_k;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    // Attached flop: JK, negedge-triggered; q_force pulls only the feedback low.
    always @(negedge clk) begin
        case ({j, k})
            2'b01: flop_q <= 1'b0;
            2'b10: flop_q <= 1'b1;
            2'b11: flop_q <= ~flop_q;
            default: flop_q <= flop_q;
        endcase
    end
    assign q_fb = q_force ? 1'b0 : flop_q;

    jk_pattern_driver #(.WIDTH(8), .CNT_W(8)) dut (
        .CLK        (clk),
        .RST        (rst),
        .DATA_IN    (data_in),
        .LOAD_VALID (load_valid),
        .LOAD_READY (load_ready),
        .J          (j),
        .K          (k),
        .Q_FB       (q_fb),
        .BUSY       (busy),
        .DONE       (done),
        .ERR        (err),
        .ERR_CNT    (err_cnt)
    );

    jk_excite u_ref_excite (.q_cur(ex_q), .q_next(ex_n), .j(ex_j), .k(ex_k));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit pattern: optional handshake, per-bit J/K checks, DONE checks.
    // f_lo..f_hi: iterations during which Q_FB is forced low; pulse_i: stray LOAD_VALID.
    task automatic run(input string tag, input logic [7:0] pat, input logic [7:0] expj,
                       input logic [7:0] expk, input int f_lo, input int f_hi,
                       input int pulse_i, input bit skip_start, input bit hold,
                       input logic [7:0] next_data, input bit exp_err);
        if (!skip_start) begin
            data_in = pat;
            load_valid = 1'b1;
        end
        tick();
        if (!hold) load_valid = 1'b0;
        data_in = next_data;
        for (int i = 0; i < 8; i++) begin
            q_force = (i >= f_lo) && (i <= f_hi);
            if (!hold) begin
                load_valid = (i == pulse_i);
                data_in    = (i == pulse_i) ? 8'h55 : next_data;
            end
            chk($sformatf("%s_j%0d", tag, i), {31'd0, j}, {31'd0, expj[i]});
            chk($sformatf("%s_k%0d", tag, i), {31'd0, k}, {31'd0, expk[i]});
            chk($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, 32'd1);
            if ((f_lo >= 0) && (i == f_lo + 1))
                chk($sformatf("%s_err_early", tag), {31'd0, err}, {31'd0, CHK_EN});
            tick();
        end
        q_force = 1'b0;
        if (!hold) load_valid = 1'b0;
        $display("%s pattern=%02h done=%0b ready=%0b busy=%0b err=%0b err_cnt=%0d q=%0b",
                 tag, pat, done, load_ready, busy, err, err_cnt, flop_q);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_ready"}, {31'd0, load_ready}, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        chk({tag, "_cnt"}, {24'd0, err_cnt}, exp_cnt);
        chk({tag, "_flop_q"}, {31'd0, flop_q}, {31'd0, pat[7]});
        if (!hold) begin
            tick();
            chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        // Reference excitation unit against the hand table.
        for (int v = 0; v < 4; v++) begin
            logic [1:0] vv;
            logic [1:0] tbl;
            vv = 2'(v);
            ex_q = vv[1];
            ex_n = vv[0];
            tbl = (v == 1) ? 2'b10 : (v == 2) ? 2'b01 : 2'b00;
            #1;
            chk($sformatf("excite_%0d", v), {30'd0, ex_j, ex_k}, {30'd0, tbl});
        end

        // Reset held for two edges.
        tick();
        tick();
        $display("reset j=%0b k=%0b ready=%0b busy=%0b done=%0b err_cnt=%0d", j, k, load_ready, busy, done, err_cnt);
        chk("rst_j", {31'd0, j}, 32'd0);
        chk("rst_k", {31'd0, k}, 32'd1);
        chk("rst_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_cnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        $display("release j=%0b k=%0b ready=%0b", j, k, load_ready);
        chk("rel_j", {31'd0, j}, 32'd0);
        chk("rel_k", {31'd0, k}, 32'd0);
        chk("rel_ready", {31'd0, load_ready}, 32'd1);

        // B2 from q_m=0: J at bits 1,4,7; K at bits 2,6.
        run("b2", 8'hB2, 8'b1001_0010, 8'b0100_0100, -1, -1, -1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Back-to-back FF then 00 with LOAD_VALID held high.
        run("ff_b2b", 8'hFF, 8'h00, 8'h00, -1, -1, -1, 1'b0, 1'b1, 8'h00, 1'b0);
        run("00_b2b", 8'h00, 8'h00, 8'h01, -1, -1, -1, 1'b1, 1'b0, 8'h00, 1'b0);

        // Feedback forced low while bits 3 and 4 are checked.
        exp_cnt = CHK_EN ? 2 : 0;
        run("ff_err", 8'hFF, 8'h01, 8'h00, 3, 4, -1, 1'b0, 1'b0, 8'h00, CHK_EN);
        run("00_clr", 8'h00, 8'h00, 8'h01, -1, -1, -1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Reset during bit 4 of FF.
        data_in = 8'hFF;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        $display("mid_reset j=%0b k=%0b busy=%0b done=%0b ready=%0b", j, k, busy, done, load_ready);
        chk("mid_k", {31'd0, k}, 32'd1);
        chk("mid_j", {31'd0, j}, 32'd0);
        chk("mid_busy_rst", {31'd0, busy}, 32'd0);
        chk("mid_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        exp_cnt = 0;
        tick();
        chk("mid_rel_ready", {31'd0, load_ready}, 32'd1);
        chk("mid_rel_done", {31'd0, done}, 32'd0);
        chk("mid_rel_cnt", {24'd0, err_cnt}, 32'd0);
        // 01 from q_m=0 needs J on bit 0, then K on bit 1.
        run("01_after_rst", 8'h01, 8'h01, 8'h02, -1, -1, -1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Stray LOAD_VALID with different data while busy.
        run("b2_pulse", 8'hB2, 8'b1001_0010, 8'b0100_0100, -1, -1, 3, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("pulse_idle_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
